// File: rtl/wb_master.sv
// Single-outstanding Wishbone B3 classic initiator: command stream in, one bus cycle, response stream out.
// Optional bus timeout abort is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH-1:0]   cmd_dat,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic [SELECT_WIDTH-1:0] sel_o,
    output logic                    we_o,
    output logic                    cyc_o,
    output logic                    stb_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic                    ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   adr_nxt;
    logic [DATA_WIDTH-1:0]   dat_nxt;
    logic [SELECT_WIDTH-1:0] sel_nxt;
    logic                    we_nxt;
    logic                    cyc_nxt;
    logic                    rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   rsp_dat_nxt;
    logic                    rsp_err_nxt;
    logic                    timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : 32;

    logic [CNT_W-1:0] bus_cnt;

    // Held at zero outside BUS, so it is already cleared on BUS entry.
    always_ff @(posedge clk) begin
        if (!rst_n || state != BUS) begin
            bus_cnt <= '0;
        end else if (!ack_i) begin
            bus_cnt <= bus_cnt + 1'b1;
        end
    end

    assign timeout_hit = (bus_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign cmd_ready = rst_n && (state == IDLE);
    assign stb_o     = cyc_o;

    always_comb begin
        state_nxt     = state;
        adr_nxt       = adr_o;
        dat_nxt       = dat_o;
        sel_nxt       = sel_o;
        we_nxt        = we_o;
        cyc_nxt       = cyc_o;
        rsp_valid_nxt = rsp_valid;
        rsp_dat_nxt   = rsp_dat;
        rsp_err_nxt   = rsp_err;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    adr_nxt   = cmd_adr;
                    dat_nxt   = cmd_dat;
                    sel_nxt   = cmd_sel;
                    we_nxt    = cmd_we;
                    cyc_nxt   = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                // An ack in the final timeout cycle still completes normally.
                if (ack_i) begin
                    cyc_nxt       = 1'b0;
                    rsp_dat_nxt   = dat_i;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (timeout_hit) begin
                    cyc_nxt       = 1'b0;
                    rsp_dat_nxt   = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            adr_o     <= '0;
            dat_o     <= '0;
            sel_o     <= '0;
            we_o      <= 1'b0;
            cyc_o     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            adr_o     <= adr_nxt;
            dat_o     <= dat_nxt;
            sel_o     <= sel_nxt;
            we_o      <= we_nxt;
            cyc_o     <= cyc_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_dat   <= rsp_dat_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

endmodule
